// File: rtl/sbox_share_sched.sv
// Shares LANES AES S-box lanes between a 128-bit state requester and a 32-bit key-word requester.
// Define SBOX_ARB_FIXED_PRIO_EN to make KEY win every tie instead of round robin.

module sbox_lane (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign y = SBOX[a];
endmodule

module sbox_share_sched #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st_valid,
   output logic         st_ready,
   input  logic [127:0] st_in,
   output logic [127:0] st_out,
   output logic         st_done,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [31:0]  key_in,
   output logic [31:0]  key_out,
   output logic         key_done,
   output logic         busy
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam int ST_CHUNKS  = 16 / LANES;
   localparam int KEY_CHUNKS = 4 / LANES;

   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("sbox_share_sched: LANES must be 1, 2 or 4");
   end

   logic [1:0]             state;
   logic [3:0]             cnt;
   logic                   gnt_key;
   logic [127:0]           work;
   logic                   idle, tie, pick_key, last_chunk;
   logic [LANES-1:0][3:0]  bidx;
   logic [LANES-1:0][7:0]  lane_in, lane_out;

   assign idle = (state == IDLE);
   assign tie  = st_valid & key_valid;
   assign busy = ~idle;

`ifdef SBOX_ARB_FIXED_PRIO_EN
   assign pick_key = key_valid;
`else
   logic last_key;
   // Tie goes to whoever did not win last; last_key resets to STATE so KEY wins first.
   assign pick_key = key_valid & (~st_valid | ~last_key);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_key <= 1'b0;
      else if (idle && (st_valid || key_valid))
         last_key <= pick_key;
   end
`endif

   // The tie loser sees ready drop so its handshake does not complete.
   assign st_ready  = idle & ~(tie & pick_key);
   assign key_ready = idle & ~(tie & ~pick_key);

   assign last_chunk = gnt_key ? (cnt == 4'(KEY_CHUNKS - 1)) : (cnt == 4'(ST_CHUNKS - 1));

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         bidx[l]    = cnt * 4'(LANES) + 4'(l);
         lane_in[l] = work[8*(4'd15 - bidx[l]) +: 8];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sbox_lane u_lane (.a(lane_in[l]), .y(lane_out[l]));
   end

   // Key words sit in the top 32 bits of work so byte i has the same position for both requesters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         gnt_key  <= 1'b0;
         work     <= '0;
         st_out   <= '0;
         key_out  <= '0;
         st_done  <= 1'b0;
         key_done <= 1'b0;
      end else begin
         st_done  <= 1'b0;
         key_done <= 1'b0;
         case (state)
            IDLE: begin
               if (st_valid || key_valid) begin
                  gnt_key <= pick_key;
                  cnt     <= '0;
                  work    <= pick_key ? {key_in, 96'd0} : st_in;
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  if (gnt_key)
                     key_out[8*(2'd3 - bidx[l][1:0]) +: 8] <= lane_out[l];
                  else
                     st_out[8*(4'd15 - bidx[l]) +: 8] <= lane_out[l];
               end
               cnt <= cnt + 4'd1;
               if (last_chunk)
                  state <= DONE;
            end
            DONE: begin
               st_done  <= ~gnt_key;
               key_done <= gnt_key;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sbox_share_sched.sv
// Scoreboard bench for sbox_share_sched: expected results are queued at each handshake
// from an arithmetic GF(2^8) S-box model and checked when the matching done pulse appears.
`timescale 1ns/1ps
module tb_sbox_share_sched;
   localparam int LANES = 4;
   localparam int N_ST  = 16 / LANES;
   localparam int N_KEY = 4 / LANES;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         st_valid = 1'b0, key_valid = 1'b0;
   logic [127:0] st_in = '0;
   logic [31:0]  key_in = '0;
   logic         st_ready, key_ready, st_done, key_done, busy;
   logic [127:0] st_out;
   logic [31:0]  key_out;

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [7:0] tbl [256];

   typedef struct {
      bit           is_key;
      logic [127:0] val;
      int           hs;
   } exp_t;
   exp_t sb[$];
   bit   glog[$];

   sbox_share_sched #(.LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in), .st_out(st_out), .st_done(st_done),
      .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_out(key_out),
      .key_done(key_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] v);
      logic [7:0] inv = '0;
      for (int i = 1; i < 256; i++)
         if (gmul(v, 8'(i)) == 8'h01) inv = 8'(i);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] xf_st(input logic [127:0] d);
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = tbl[d[127-8*i -: 8]];
      return r;
   endfunction

   function automatic logic [31:0] xf_w(input logic [31:0] d);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) r[31-8*i -: 8] = tbl[d[31-8*i -: 8]];
      return r;
   endfunction

   // Handshake monitor: values seen here are the pre-edge ones, i.e. what the DUT samples.
   always @(posedge clk) begin
      if (rst_n) begin
         if (st_valid && st_ready) begin
            exp_t e;
            e.is_key = 1'b0; e.val = xf_st(st_in); e.hs = cyc;
            sb.push_back(e); glog.push_back(1'b0);
         end
         if (key_valid && key_ready) begin
            exp_t e;
            e.is_key = 1'b1; e.val = {96'd0, xf_w(key_in)}; e.hs = cyc;
            sb.push_back(e); glog.push_back(1'b1);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (st_done || key_done)) begin
         chk("one_done", 128'(st_done & key_done), 128'(0));
         chk("sb_pending", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("done_kind", 128'(key_done), 128'(e.is_key));
            chk("latency", 128'(cyc - 1 - e.hs), 128'((e.is_key ? N_KEY : N_ST) + 1));
            chk(e.is_key ? "key_out" : "st_out", e.is_key ? {96'd0, key_out} : st_out, e.val);
         end
      end
   end

   task automatic send_st(input logic [127:0] d);
      bit ok = 1'b0;
      st_in = d; st_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         #1 ok = st_ready;
         @(posedge clk);
      end
      #1 st_valid = 1'b0;
      chk("st_handshake", 128'(ok), 128'(1));
   endtask

   task automatic send_key(input logic [31:0] d);
      bit ok = 1'b0;
      key_in = d; key_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         #1 ok = key_ready;
         @(posedge clk);
      end
      #1 key_valid = 1'b0;
      chk("key_handshake", 128'(ok), 128'(1));
   endtask

   task automatic drain();
      int i = 0;
      while ((sb.size() != 0 || busy) && i < 300) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      @(negedge clk);
      chk("drain", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] a;
      int target;
      for (int i = 0; i < 256; i++) tbl[i] = sbox_ref(8'(i));

      repeat (3) @(negedge clk);
      chk("rst_st_out", st_out, 128'd0);
      chk("rst_key_out", 128'(key_out), 128'd0);
      chk("rst_dones", 128'({st_done, key_done}), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_readies", 128'({st_ready, key_ready}), 128'(2'b11));

      // Single key word, held valid: ready must drop the cycle after the handshake
      @(negedge clk);
      send_key(32'h00530001);
      @(negedge clk);
      chk("key_ready_busy", 128'({key_ready, st_ready, busy}), 128'(3'b001));
      drain();
      chk("key_plan", 128'(key_out), 128'(32'h63ED637C));

      send_st(128'd0);
      drain();
      chk("st_zero", st_out, {16{8'h63}});

      send_st(128'h000102030405060708090a0b0c0d0e0f);
      drain();
      chk("st_seq", st_out, 128'h637C777BF26B6FC53001672BFED7AB76);
      chk("key_hold", 128'(key_out), 128'(32'h63ED637C));

      // Tie with both valids held
`ifdef SBOX_ARB_FIXED_PRIO_EN
      target = 3;
`else
      target = 4;
`endif
      glog.delete();
      st_in = 128'h0123456789abcdeffedcba9876543210;
      key_in = 32'hdeadbeef;
      st_valid = 1'b1; key_valid = 1'b1;
      for (int i = 0; i < 200 && glog.size() < target; i++) @(negedge clk);
      st_valid = 1'b0; key_valid = 1'b0;
      drain();
      chk("tie_count", 128'(glog.size()), 128'(target));
      for (int i = 0; i < glog.size(); i++) begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
         chk("tie_grant", 128'(glog[i]), 128'(1));
`else
         chk("tie_grant", 128'(glog[i]), 128'((i % 2) == 0));
`endif
      end

      // Reset mid-RUN of a state request
      send_st(128'hffeeddccbbaa99887766554433221100);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_st_out", st_out, 128'd0);
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_done", 128'(st_done), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_readies", 128'({st_ready, key_ready}), 128'(2'b11));
      repeat (8) @(negedge clk);
      send_key(32'hFFFFFFFF);
      drain();
      chk("key_ff", 128'(key_out), 128'(32'h16161616));

      // Input changed after the handshake must not leak into the result
      a = 128'h00112233445566778899aabbccddeeff;
      send_st(a);
      st_in = ~a;
      drain();
      chk("st_captured", st_out, xf_st(a));

      // Random back-to-back traffic
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1)
            send_key($urandom);
         else
            send_st({$urandom, $urandom, $urandom, $urandom});
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
